// File: rtl/ifetch_unit_if.sv
// Handshake/bus bundle for the instruction fetch stage.
//  PC-control side : next_pc_valide, next_pc, pc_ready, flush
//  Memory side     : mem_req, mem_addr, mem_gnt, mem_rvalid, mem_rdata
//  Ifetch side     : instr_valide, instruction, instr_addr, ok_i
// master = the fetch unit, slave = its environment (PC gen, memory, decode).
interface ifetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            next_pc_valide;
  logic [XLEN-1:0] next_pc;
  logic            pc_ready;
  logic            flush;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            instr_valide;
  logic [31:0]     instruction;
  logic [XLEN-1:0] instr_addr;
  logic            ok_i;

  modport master (
    input  next_pc_valide, next_pc, flush, mem_gnt, mem_rvalid, mem_rdata, ok_i,
    output pc_ready, mem_req, mem_addr, instr_valide, instruction, instr_addr
  );

  modport slave (
    output next_pc_valide, next_pc, flush, mem_gnt, mem_rvalid, mem_rdata, ok_i,
    input  pc_ready, mem_req, mem_addr, instr_valide, instruction, instr_addr
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage.
// Accepts fetch addresses from the PC generator, issues word reads to
// instruction memory (req/gnt, in-order rvalid), buffers returned words with
// their addresses and hands them downstream on instr_valide/ok_i.
// flush discards buffered words and all in-flight or pending fetches.
// Ports:
//  clk  - clock, rising edge
//  rst  - asynchronous active-high reset
//  bus  - ifetch_unit_if.master (PC-control, memory and ifetch handshakes)
module ifetch_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned UW = PW + 3;

  typedef enum logic {IDLE, REQ} req_state_e;

  req_state_e      state_q, state_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            stale_q, stale_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]   aq_wr_q, aq_rd_q;
  logic [XLEN-1:0] aq_q    [DEPTH];
  logic [XLEN-1:0] rb_addr_q [DEPTH];
  logic [31:0]     rb_data_q [DEPTH];

  logic            req_pending;
  logic            gnt_fire;
  logic            rv_fire;
  logic            rv_keep;
  logic            pop;
  logic            accept;
  logic            pc_ready;
  logic [UW-1:0]   used;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^bus.next_pc[1:0];

  assign req_pending = (state_q == REQ);
  assign gnt_fire    = req_pending && bus.mem_gnt;
  // rvalid with nothing outstanding is a protocol error and is ignored.
  assign rv_fire     = bus.mem_rvalid && (inflight_q != '0);
  assign rv_keep     = rv_fire && (drop_q == '0) && !bus.flush;
  assign pop         = (count_q != '0) && bus.ok_i;

  // Every pending, in-flight or buffered fetch owns one buffer slot.
  assign used     = UW'(req_pending) + UW'(inflight_q) + UW'(count_q);
  assign pc_ready = !rst && !bus.flush && (used < UW'(DEPTH)) &&
                    (!req_pending || bus.mem_gnt);
  assign accept   = bus.next_pc_valide && pc_ready;

  // Request FSM.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = REQ;
          mem_addr_d = {bus.next_pc[XLEN-1:2], 2'b00};
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (accept) begin
            state_d    = REQ;
            mem_addr_d = {bus.next_pc[XLEN-1:2], 2'b00};
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding/drop bookkeeping and buffer occupancy.
  always_comb begin
    inflight_d = inflight_q + CW'(gnt_fire) - CW'(rv_fire);
    drop_d     = drop_q;
    stale_d    = stale_q;
    count_d    = count_q;
    if (bus.flush) begin
      // Everything still outstanding after this cycle belongs to the old
      // stream; drop_q is already a subset of inflight_q so it is not added.
      drop_d  = inflight_d;
      // A request not yet granted is kept on the bus; its reply is marked
      // for dropping once the grant arrives.
      stale_d = req_pending && !bus.mem_gnt;
      count_d = '0;
    end else begin
      drop_d = drop_q + CW'(gnt_fire && stale_q) - CW'(rv_fire && (drop_q != '0));
      if (gnt_fire) stale_d = 1'b0;
      count_d = count_q + CW'(rv_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      stale_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        aq_q[i]      <= '0;
        rb_addr_q[i] <= '0;
        rb_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      if (gnt_fire) begin
        aq_q[aq_wr_q] <= mem_addr_q;
        aq_wr_q       <= aq_wr_q + 1'b1;
      end
      if (rv_fire) aq_rd_q <= aq_rd_q + 1'b1;
      if (rv_keep) begin
        rb_addr_q[wr_ptr_q] <= aq_q[aq_rd_q];
        rb_data_q[wr_ptr_q] <= bus.mem_rdata;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (bus.flush) rd_ptr_q <= wr_ptr_q;
      else if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.pc_ready     = pc_ready;
  assign bus.mem_req      = req_pending;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.instr_valide = (count_q != '0);
  assign bus.instruction  = rb_data_q[rd_ptr_q];
  assign bus.instr_addr   = rb_addr_q[rd_ptr_q];
endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  logic clk;
  logic rst;
  logic gnt_en;
  int   lat;
  int   cyc;
  int   vectors;
  int   miscompares;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  exp_t  sb[$];
  mreq_t mq[$];

  ifetch_unit_if #(.XLEN(32)) bus ();

  ifetch_unit #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.mem_gnt = gnt_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout, got no event expected event", name);
  endtask

  // Memory model: grants sampled just before the edge, replies returned
  // in order after lat cycles, at most one per cycle.
  always @(negedge clk) begin
    bus.mem_rvalid = 1'b0;
    if (rst) begin
      mq.delete();
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mdata(mq[0].a);
      void'(mq.pop_front());
    end
    #4;
    if (!rst && bus.mem_req && bus.mem_gnt) mq.push_back('{a: bus.mem_addr, due: cyc + lat});
    cyc++;
  end

  // Scoreboard monitor: every handshake on the output is checked.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (!rst && bus.instr_valide && bus.ok_i) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got addr %h expected none", bus.instr_addr);
      end else begin
        e = sb.pop_front();
        chk("out_addr", bus.instr_addr, e.a);
        chk("out_data", bus.instruction, e.d);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input bit expect_out);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    bus.next_pc_valide = 1'b1;
    bus.next_pc        = a;
    while (!done && n < 100) begin
      #4;
      if (bus.pc_ready) begin
        done = 1;
        if (expect_out) sb.push_back('{a: a, d: mdata(a)});
      end
      @(negedge clk);
      n++;
    end
    bus.next_pc_valide = 1'b0;
    if (!done) timeout("fetch_accept");
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!bus.instr_valide && n < 100);
    if (!bus.instr_valide) timeout("wait_valid");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while ((sb.size() != 0 || mq.size() != 0 || bus.instr_valide) && n < 200);
    if (sb.size() != 0 || mq.size() != 0 || bus.instr_valide) timeout("drain");
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors            = 0;
    miscompares        = 0;
    cyc                = 0;
    lat                = 2;
    gnt_en             = 1'b1;
    rst                = 1'b1;
    bus.next_pc_valide = 1'b1;
    bus.next_pc        = 32'h40;
    bus.flush          = 1'b0;
    bus.ok_i           = 1'b1;
    bus.mem_rdata      = '0;

    // Reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valide), 32'd0);
    chk("rst_pc_ready", 32'(bus.pc_ready), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    bus.next_pc_valide = 1'b0;
    rst = 1'b0;
    #4;
    chk("rel_pc_ready", 32'(bus.pc_ready), 32'd1);
    @(negedge clk);

    // Single fetch
    lat = 2;
    fetch(32'h100, 1);
    wait_valid();
    chk("single_instr", bus.instruction, 32'h0000_0013);
    chk("single_addr", bus.instr_addr, 32'h100);
    @(negedge clk);
    #3;
    chk("single_popped", 32'(bus.instr_valide), 32'd0);
    wait_drain();

    // Backpressure
    lat = 1;
    bus.ok_i = 1'b0;
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 1);
    fork
      fetch(32'h10, 1);
      begin
        repeat (8) @(negedge clk);
        #3;
        chk("bp_pc_ready", 32'(bus.pc_ready), 32'd0);
        chk("bp_mem_req", 32'(bus.mem_req), 32'd0);
        chk("bp_valid", 32'(bus.instr_valide), 32'd1);
        chk("bp_head", bus.instr_addr, 32'h0);
        @(negedge clk);
        bus.ok_i = 1'b1;
      end
    join
    wait_drain();

    // Flush
    lat = 4;
    bus.ok_i = 1'b0;
    fetch(32'h1C, 0);
    wait_valid();
    @(negedge clk);
    fetch(32'h20, 0);
    fetch(32'h24, 0);
    bus.flush = 1'b1;
    #4;
    chk("flush_pc_ready", 32'(bus.pc_ready), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #3;
    chk("flush_empty", 32'(bus.instr_valide), 32'd0);
    @(negedge clk);
    bus.ok_i = 1'b1;
    fetch(32'h200, 1);
    wait_drain();

    // Grant stall
    lat = 2;
    gnt_en = 1'b0;
    fetch(32'h300, 1);
    bus.next_pc_valide = 1'b1;
    bus.next_pc        = 32'h304;
    for (int k = 0; k < 5; k++) begin
      #4;
      chk("stall_req", 32'(bus.mem_req), 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h300);
      chk("stall_pc_ready", 32'(bus.pc_ready), 32'd0);
      @(negedge clk);
    end
    bus.next_pc_valide = 1'b0;
    gnt_en = 1'b1;
    @(negedge clk);
    #3;
    chk("stall_req_done", 32'(bus.mem_req), 32'd0);
    wait_drain();

    // Mid-operation reset
    lat = 1;
    bus.ok_i = 1'b0;
    fetch(32'h400, 0);
    fetch(32'h404, 0);
    fetch(32'h408, 0);
    repeat (4) @(negedge clk);
    #3;
    chk("mid_valid", 32'(bus.instr_valide), 32'd1);
    chk("mid_head", bus.instr_addr, 32'h400);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.instr_valide), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.ok_i = 1'b1;
    #3;
    chk("mid_rel_valid", 32'(bus.instr_valide), 32'd0);
    @(negedge clk);
    fetch(32'h500, 1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
